// File: rtl/max_sched_pkg.sv
// Shared types and defaults for the max_job_sched scheduler slice.
package max_sched_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned INP_BW_DEF  = 8;
  localparam int unsigned IDX_W_DEF   = $clog2(NUM_REQ_DEF);
  localparam int unsigned STATE_W     = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational circular-priority pick: first set request at or above ptr.
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_i;

  // Walk the requesters starting at ptr, wrapping once; the first hit wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    pos_i = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= N) pos = pos - N;
      pos_i = IDX_W'(pos);
      if (!any && req[pos_i]) begin
        any        = 1'b1;
        gnt[pos_i] = 1'b1;
        idx        = pos_i;
      end
    end
  end

endmodule

// File: rtl/max_job_sched.sv
// Round-robin scheduler sharing one max_computer engine among NUM_REQ requesters.
// Optional RUN-state timeout enabled by defining MAX_JOB_SCHED_TMO_EN.
module max_job_sched
  import max_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned INP_BW  = INP_BW_DEF,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic                      i_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        i_req,
  output logic [NUM_REQ-1:0]        o_gnt,
  input  logic [NUM_REQ-1:0]        i_rdy_vec,
  input  logic [NUM_REQ*INP_BW-1:0] i_rdata_vec,
  output logic [NUM_REQ-1:0]        o_rd_vec,
  output logic                      o_eng_start_p,
  output logic                      o_eng_rdy,
  output logic [INP_BW-1:0]         o_eng_rdata,
  input  logic                      i_eng_rd,
  input  logic                      i_eng_vld_p,
  input  logic [INP_BW-1:0]         i_eng_max_val,
  output logic [NUM_REQ-1:0]        o_done_p,
  output logic [INP_BW-1:0]         o_result,
  output logic                      o_busy,
  output logic                      o_err_p
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Reject illegal configurations at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TMO_CYC < 1) begin : g_param_err
    $error("max_job_sched: NUM_REQ must be 2..8 and TMO_CYC >= 1");
  end

  sched_state_e       state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] last_done_q;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic               start_d, busy_d, err_d;
  logic [INP_BW-1:0]  result_d;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               tmo_hit;

  // A requester just served is masked for one IDLE cycle so others get a turn.
  assign elig = i_req & ~last_done_q;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef MAX_JOB_SCHED_TMO_EN
  localparam int unsigned CNT_W = $clog2(TMO_CYC) + 1;
  logic [CNT_W-1:0] run_cnt_q;

  // Count RUN cycles; held at zero outside RUN so it restarts on every entry.
  always_ff @(posedge i_clk) begin
    if (reset || state_q != S_RUN) run_cnt_q <= '0;
    else                           run_cnt_q <= run_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == S_RUN) && (run_cnt_q == CNT_W'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and next-value logic for all registered outputs.
  always_comb begin
    state_d   = state_q;
    gnt_d     = o_gnt;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    start_d   = 1'b0;
    done_d    = '0;
    err_d     = 1'b0;
    result_d  = o_result;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          gnt_d     = arb_gnt;
          gnt_idx_d = arb_idx;
          start_d   = 1'b1;
          state_d   = S_START;
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (i_eng_vld_p) begin
          result_d = i_eng_max_val;
          done_d   = o_gnt;
          state_d  = S_DONE;
        end else if (tmo_hit) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = o_gnt;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Output and bookkeeping registers.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      o_gnt         <= '0;
      gnt_idx_q     <= '0;
      ptr_q         <= '0;
      o_eng_start_p <= 1'b0;
      o_done_p      <= '0;
      last_done_q   <= '0;
      o_result      <= '0;
      o_busy        <= 1'b0;
      o_err_p       <= 1'b0;
    end else begin
      o_gnt         <= gnt_d;
      gnt_idx_q     <= gnt_idx_d;
      ptr_q         <= ptr_d;
      o_eng_start_p <= start_d;
      o_done_p      <= done_d;
      last_done_q   <= o_done_p;
      o_result      <= result_d;
      o_busy        <= busy_d;
      o_err_p       <= err_d;
    end
  end

  // Zero-latency routing between the granted requester and the engine.
  always_comb begin
    o_eng_rdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (o_gnt[k]) o_eng_rdata = o_eng_rdata | i_rdata_vec[k*INP_BW +: INP_BW];
    end
  end

  assign o_eng_rdy = (state_q == S_RUN) && (|(i_rdy_vec & o_gnt));
  assign o_rd_vec  = o_gnt & {NUM_REQ{i_eng_rd}};

endmodule

// File: tb/tb_max_job_sched.sv
// Directed testbench for max_job_sched (NUM_REQ=4, INP_BW=8, TMO_CYC=16).
module tb_max_job_sched;

  logic        i_clk = 1'b0;
  logic        reset;
  logic [3:0]  i_req;
  logic [3:0]  o_gnt;
  logic [3:0]  i_rdy_vec;
  logic [31:0] i_rdata_vec;
  logic [3:0]  o_rd_vec;
  logic        o_eng_start_p;
  logic        o_eng_rdy;
  logic [7:0]  o_eng_rdata;
  logic        i_eng_rd;
  logic        i_eng_vld_p;
  logic [7:0]  i_eng_max_val;
  logic [3:0]  o_done_p;
  logic [7:0]  o_result;
  logic        o_busy;
  logic        o_err_p;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  max_job_sched #(.NUM_REQ(4), .INP_BW(8), .TMO_CYC(16)) dut (
    .i_clk         (i_clk),
    .reset         (reset),
    .i_req         (i_req),
    .o_gnt         (o_gnt),
    .i_rdy_vec     (i_rdy_vec),
    .i_rdata_vec   (i_rdata_vec),
    .o_rd_vec      (o_rd_vec),
    .o_eng_start_p (o_eng_start_p),
    .o_eng_rdy     (o_eng_rdy),
    .o_eng_rdata   (o_eng_rdata),
    .i_eng_rd      (i_eng_rd),
    .i_eng_vld_p   (i_eng_vld_p),
    .i_eng_max_val (i_eng_max_val),
    .o_done_p      (o_done_p),
    .o_result      (o_result),
    .o_busy        (o_busy),
    .o_err_p       (o_err_p)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Wait for a grant (bounded), check its latency, then serve it with result val.
  task automatic run_job(input string tag, input logic [3:0] exp_gnt,
                         input int exp_wait, input logic [7:0] val);
    int w = 0;
    do begin step(); w++; end while (o_gnt == 4'b0 && w < 12);
    chk({tag, "_wait"},  32'(w), 32'(exp_wait));
    chk({tag, "_gnt"},   32'(o_gnt), 32'(exp_gnt));
    chk({tag, "_start"}, 32'(o_eng_start_p), 32'd1);
    step();
    chk({tag, "_start_gone"}, 32'(o_eng_start_p), 32'd0);
    i_eng_vld_p   = 1'b1;
    i_eng_max_val = val;
    step();
    i_eng_vld_p = 1'b0;
    chk({tag, "_done"},   32'(o_done_p), 32'(exp_gnt));
    chk({tag, "_result"}, 32'(o_result), 32'(val));
    chk({tag, "_gnt_dn"}, 32'(o_gnt), 32'(exp_gnt));
    step();
    chk({tag, "_gnt_clr"},  32'(o_gnt), 32'd0);
    chk({tag, "_done_clr"}, 32'(o_done_p), 32'd0);
  endtask

  initial begin
    int w;
    reset         = 1'b1;
    i_req         = '0;
    i_rdy_vec     = '0;
    i_rdata_vec   = '0;
    i_eng_rd      = 1'b0;
    i_eng_vld_p   = 1'b0;
    i_eng_max_val = '0;
    do_reset();

    chk("rst_gnt",    32'(o_gnt), 32'd0);
    chk("rst_busy",   32'(o_busy), 32'd0);
    chk("rst_result", 32'(o_result), 32'd0);
    chk("rst_start",  32'(o_eng_start_p), 32'd0);
    chk("rst_err",    32'(o_err_p), 32'd0);

    // Single requester.
    i_req = 4'b0001;
    run_job("single", 4'b0001, 1, 8'hA7);
    i_req = '0;
    chk("single_busy_idle", 32'(o_busy), 32'd0);

    // Two simultaneous requesters alternate starting from pointer 0.
    do_reset();
    i_req = 4'b1010;
    run_job("sim0", 4'b0010, 1, 8'h11);
    run_job("sim1", 4'b1000, 1, 8'h22);
    run_job("sim2", 4'b0010, 1, 8'h33);
    run_job("sim3", 4'b1000, 1, 8'h44);
    i_req = '0;

    // Lone requester re-requesting: masked one cycle, so one extra wait.
    i_req = 4'b0001;
    run_job("rereq0", 4'b0001, 1, 8'h55);
    run_job("rereq1", 4'b0001, 2, 8'h66);
    i_req = '0;

    // Data routing on requester 2 (pointer now 1); request dropped mid-job.
    i_req = 4'b0100;
    step();
    chk("mux_gnt", 32'(o_gnt), 32'h4);
    i_rdy_vec = 4'b1111;
    #1;
    chk("mux_rdy_start", 32'(o_eng_rdy), 32'd0);
    step();
    i_req       = '0;
    i_rdy_vec   = 4'b1011;
    i_rdata_vec = 32'h115C_2233;
    i_eng_rd    = 1'b0;
    #1;
    chk("mux_rdy_off", 32'(o_eng_rdy), 32'd0);
    chk("mux_data",    32'(o_eng_rdata), 32'h5C);
    chk("mux_rd_off",  32'(o_rd_vec), 32'd0);
    i_rdy_vec   = 4'b0100;
    i_rdata_vec = 32'hEE5C_99AA;
    i_eng_rd    = 1'b1;
    #1;
    chk("mux_rdy_on", 32'(o_eng_rdy), 32'd1);
    chk("mux_data2",  32'(o_eng_rdata), 32'h5C);
    chk("mux_rd_on",  32'(o_rd_vec), 32'h4);
    i_eng_rd      = 1'b0;
    i_eng_vld_p   = 1'b1;
    i_eng_max_val = 8'h9E;
    step();
    i_eng_vld_p = 1'b0;
    i_rdy_vec   = '0;
    chk("mux_done",   32'(o_done_p), 32'h4);
    chk("mux_result", 32'(o_result), 32'h9E);
    step();
    chk("mux_gnt_clr",  32'(o_gnt), 32'd0);
    chk("mux_data_clr", 32'(o_eng_rdata), 32'd0);

    // Reset in RUN (pointer 3 beforehand), then a stray engine result.
    i_req = 4'b0010;
    step();
    chk("rr_gnt", 32'(o_gnt), 32'h2);
    step();
    i_req = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_gnt_clr", 32'(o_gnt), 32'd0);
    chk("rr_busy",    32'(o_busy), 32'd0);
    chk("rr_result",  32'(o_result), 32'd0);
    i_eng_vld_p   = 1'b1;
    i_eng_max_val = 8'hFF;
    step();
    i_eng_vld_p = 1'b0;
    chk("stray_result", 32'(o_result), 32'd0);
    chk("stray_done",   32'(o_done_p), 32'd0);
    chk("stray_busy",   32'(o_busy), 32'd0);
    i_req = 4'b1010;
    run_job("ptr0", 4'b0010, 1, 8'h3C);
    i_req = '0;

    // RUN with no engine result (pointer now 2).
    i_req = 4'b0100;
    step();
    chk("tmo_gnt", 32'(o_gnt), 32'h4);
    step();
    i_req = '0;
`ifdef MAX_JOB_SCHED_TMO_EN
    w = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (o_err_p !== 1'b0 || o_done_p !== 4'b0) w++;
    end
    chk("tmo_early", 32'(w), 32'd0);
    step();
    chk("tmo_err",    32'(o_err_p), 32'd1);
    chk("tmo_done",   32'(o_done_p), 32'h4);
    chk("tmo_result", 32'(o_result), 32'd0);
    step();
    chk("tmo_err_clr", 32'(o_err_p), 32'd0);
    chk("tmo_gnt_clr", 32'(o_gnt), 32'd0);
`else
    w = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (o_err_p !== 1'b0 || o_done_p !== 4'b0) w++;
    end
    chk("wait_no_err", 32'(w), 32'd0);
    chk("wait_busy",   32'(o_busy), 32'd1);
    i_eng_vld_p   = 1'b1;
    i_eng_max_val = 8'h77;
    step();
    i_eng_vld_p = 1'b0;
    chk("wait_done",   32'(o_done_p), 32'h4);
    chk("wait_result", 32'(o_result), 32'h77);
    step();
    chk("wait_gnt_clr", 32'(o_gnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max_job_sched.md
Name: max_job_sched

Overview:
- Round-robin scheduler that shares one max_computer engine between NUM_REQ requesters.
- Grants one requester at a time and pulses the engine start.
- Routes the granted requester's data stream and read strobe between it and the engine, then returns the engine's max result to that requester with a done pulse.
- Sits between the requester FIFOs/memories and the single engine instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
INP_BW, 8, sample/result width; must match the engine
TMO_CYC, 1024, RUN-state cycle limit; used only with the optional feature

Ports:
i_clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  NUM_REQ  per-requester job request (level); held until its o_done_p bit
o_gnt  out  NUM_REQ  one-hot grant (registered); high from START through DONE
i_rdy_vec  in  NUM_REQ  per-requester data-valid
i_rdata_vec  in  NUM_REQ*INP_BW  packed data; requester k occupies bits [k*INP_BW +: INP_BW]
o_rd_vec  out  NUM_REQ  engine read strobe, demuxed to the granted requester
o_eng_start_p  out  1  one-cycle engine start pulse (registered)
o_eng_rdy  out  1  data-valid to engine: OR of (i_rdy_vec & o_gnt), forced 0 outside RUN
o_eng_rdata  out  INP_BW  granted requester's data slice; 0 when no grant
i_eng_rd  in  1  engine read strobe
i_eng_vld_p  in  1  engine result-valid pulse
i_eng_max_val  in  INP_BW  engine result
o_done_p  out  NUM_REQ  one-cycle completion pulse to the granted requester
o_result  out  INP_BW  captured result; stable from the DONE cycle until the next capture
o_busy  out  1  high whenever state is not IDLE
o_err_p  out  1  timeout pulse; constant 0 without the optional feature

Behaviour:
- Reset, synchronous: state=IDLE, rr pointer=0. All outputs are 0: o_gnt, o_eng_start_p, o_done_p, o_result, o_busy, o_err_p. Routed outputs are 0 because o_gnt=0.
- States: IDLE, START, RUN, DONE.
- IDLE:
  - Eligible set = i_req, excluding any bit pulsed on o_done_p in the previous cycle.
  - If the eligible set is non-empty, pick the first set bit at or above the pointer (circular search), register o_gnt, go to START.
- START, exactly one cycle: o_eng_start_p=1, then go to RUN.
- RUN:
  - o_eng_rdy, o_eng_rdata and o_rd_vec = o_gnt & {NUM_REQ{i_eng_rd}} are combinational from the grant.
  - On i_eng_vld_p: capture i_eng_max_val into o_result, go to DONE.
- DONE, exactly one cycle:
  - o_done_p = o_gnt.
  - Pointer = (winner index + 1) mod NUM_REQ.
  - o_gnt clears on exit; go to IDLE.
- Latency: request seen in IDLE at cycle t → o_gnt and o_eng_start_p at t+1 → RUN from t+2. After DONE there is at least one IDLE cycle before the next grant.
- The scheduler adds 0 cycles to the data path; the mux is combinational.
- i_req dropped mid-job: ignored; the job completes and o_done_p still pulses.
- Fairness: a requester re-requesting right after its own DONE is masked for that IDLE cycle. If it is the only requester, it is granted on the following cycle.
- i_eng_vld_p outside RUN: ignored; no capture.
- Reset mid-job: scheduler returns to IDLE immediately. The engine shares the same reset, so it is restarted too.
- Requests arriving while busy: queued implicitly by level; never dropped.

Optional Feature:
- Macro MAX_JOB_SCHED_TMO_EN.
- Defined:
  - A RUN cycle counter (width clog2(TMO_CYC)+1) clears on entry to RUN.
  - After TMO_CYC RUN cycles with no i_eng_vld_p: o_err_p pulses 1 cycle, o_result=0, and the FSM goes to DONE (o_done_p pulses normally).
  - If i_eng_vld_p coincides with timeout, vld wins and o_err_p stays 0.
- Undefined: no counter; o_err_p tied 0; RUN waits indefinitely.

Decomposition:
- Package max_sched_pkg holds:
  - state enum (IDLE/START/RUN/DONE) and its width;
  - default NUM_REQ and INP_BW;
  - index width localparam clog2(NUM_REQ).
- One sub-module, rr_arbiter:
  - combinational circular priority pick from (req vector, pointer) to one-hot grant plus index;
  - the pointer register stays in max_job_sched.

Test Plan:
- Single requester: i_req=4'b0001; engine returns vld with 8'hA7 → o_gnt=0001 at t+1, one o_eng_start_p, o_done_p=0001, o_result=8'hA7.
- Simultaneous: i_req=4'b1010 held, pointer=0 → grants in order 0010, 1000, 0010, 1000; exactly one done per grant.
- Muxing: grant on requester 2, other requesters toggle rdy/data → o_eng_rdata equals slice 2 only, and o_rd_vec=0100 exactly when i_eng_rd=1.
- Re-request: requester 0 alone holds i_req after its done → one IDLE gap plus one masked cycle, then regrant; no back-to-back start pulses.
- Reset mid-RUN: assert reset for 1 cycle → next cycle o_gnt=0, o_busy=0, state IDLE, pointer=0; a later stray i_eng_vld_p is ignored.
- Timeout (macro defined, TMO_CYC=16): no vld for 16 RUN cycles → o_err_p one pulse, o_done_p to the granted bit, o_result=0.
